// File: rtl/arm_multicycle_ctrl.sv
// Multicycle control sequencer for the ARMv4-subset datapath (FETCH/EXEC/MEM/FAULT).
// Optional single-step debug gating is enabled by defining ARMCTL_SINGLE_STEP_EN.
module arm_multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CW         = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ack,
`ifdef ARMCTL_SINGLE_STEP_EN
  input  logic        step_en,
  output logic        retired,
`endif
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        mem_req,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  Flags,
  output logic [1:0]  state,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_MEM   = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_ORR  = 4'b0011;
  localparam logic [3:0] ALU_PASS = 4'b0100;

  state_t        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       s_bit, u_bit, rd_pc;
  logic       cond_ex, dp_valid, dp_cv, accept;
  logic [3:0] dp_alu;
  logic       unused_ir_bits;

  assign cond    = ir_q[31:28];
  assign op      = ir_q[27:26];
  assign cmd     = ir_q[24:21];
  assign s_bit   = ir_q[20];
  assign u_bit   = ir_q[23];
  assign rd      = ir_q[15:12];
  assign rd_pc   = (rd == 4'hF);
  assign cnt_inc = cnt_q + 1'b1;
  assign unused_ir_bits = ^{ir_q[19:16], ir_q[11:0], ir_q[22]};

`ifdef ARMCTL_SINGLE_STEP_EN
  // A rising edge of step_en arms one fetch; the token is consumed on acceptance.
  logic step_prev_q, token_q, token_d, step_rise;
  assign step_rise = step_en & ~step_prev_q;
  assign accept    = instr_valid & (~step_en | token_q | step_rise);
  assign token_d   = (token_q | step_rise) & ~(accept & (state_q == S_FETCH));
  assign retired   = PCWrite;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_prev_q <= 1'b0;
      token_q     <= 1'b0;
    end else begin
      step_prev_q <= step_en;
      token_q     <= token_d;
    end
  end
`else
  assign accept = instr_valid;
`endif

  always_comb begin
    unique case (cond)
      4'h0: cond_ex = flags_q[2];
      4'h1: cond_ex = ~flags_q[2];
      4'h2: cond_ex = flags_q[1];
      4'h3: cond_ex = ~flags_q[1];
      4'h4: cond_ex = flags_q[3];
      4'h5: cond_ex = ~flags_q[3];
      4'h6: cond_ex = flags_q[0];
      4'h7: cond_ex = ~flags_q[0];
      4'h8: cond_ex = flags_q[1] & ~flags_q[2];
      4'h9: cond_ex = ~flags_q[1] | flags_q[2];
      4'hA: cond_ex = (flags_q[3] == flags_q[0]);
      4'hB: cond_ex = (flags_q[3] != flags_q[0]);
      4'hC: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'hD: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    dp_valid = 1'b1;
    dp_cv    = 1'b0;
    dp_alu   = ALU_ADD;
    unique case (cmd)
      4'b0000: dp_alu = ALU_AND;
      4'b0010: begin dp_alu = ALU_SUB; dp_cv = 1'b1; end
      4'b0100: begin dp_alu = ALU_ADD; dp_cv = 1'b1; end
      4'b1100: dp_alu = ALU_ORR;
      4'b1010: begin dp_alu = ALU_SUB; dp_cv = 1'b1; end
      4'b1101: dp_alu = ALU_PASS;
      default: dp_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    flags_d    = flags_q;
    cnt_d      = cnt_q;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    mem_req    = 1'b0;
    ALUControl = ALU_ADD;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    fault      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (accept) begin
          ir_d    = Instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!cond_ex) begin
          PCWrite = 1'b1;
          state_d = S_FETCH;
        end else begin
          unique case (op)
            2'b00: begin
              if (dp_valid) begin
                ALUSrc     = ir_q[25];
                ALUControl = dp_alu;
                RegWrite   = (cmd != 4'b1010) && !rd_pc;
                PCSrc      = (cmd != 4'b1010) && rd_pc;
                PCWrite    = 1'b1;
                state_d    = S_FETCH;
                if (s_bit || cmd == 4'b1010) begin
                  flags_d[3:2] = ALUFlags[3:2];
                  if (dp_cv) flags_d[1:0] = ALUFlags[1:0];
                end
              end else begin
                state_d = S_FAULT;
              end
            end
            2'b01: begin
              ALUSrc     = 1'b1;
              ImmSrc     = 2'b01;
              ALUControl = u_bit ? ALU_ADD : ALU_SUB;
              RegSrc[1]  = ~s_bit;
              cnt_d      = '0;
              state_d    = S_MEM;
            end
            2'b10: begin
              ALUSrc     = 1'b1;
              ImmSrc     = 2'b10;
              RegSrc     = 2'b01;
              ALUControl = ALU_ADD;
              PCSrc      = 1'b1;
              PCWrite    = 1'b1;
              state_d    = S_FETCH;
            end
            default: state_d = S_FAULT;
          endcase
        end
      end
      S_MEM: begin
        ALUSrc     = 1'b1;
        ImmSrc     = 2'b01;
        ALUControl = u_bit ? ALU_ADD : ALU_SUB;
        RegSrc[1]  = ~s_bit;
        mem_req    = 1'b1;
        MemWrite   = ~s_bit;
        if (mem_ack) begin
          PCWrite  = 1'b1;
          RegWrite = s_bit;
          MemtoReg = s_bit;
          PCSrc    = s_bit & rd_pc;
          cnt_d    = '0;
          state_d  = S_FETCH;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(WAIT_LIMIT)) state_d = S_FAULT;
        end
      end
      default: fault = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Flags = flags_q;
  assign state = state_q;

endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
- Multicycle control sequencer for the ARMv4-subset datapath: fetches one instruction word per handshake, decodes it, evaluates the condition field against an internal NZCV register, and drives every datapath control line.
- Inserts wait states for a data memory with a req/ack handshake, and gates PC update through PCWrite.
- Sits between the instruction memory, the data memory and the datapath.

Parameters:
- WAIT_LIMIT, 16, max cycles in MEM without mem_ack before entering FAULT (minimum 1).
- CW, 5, width of the wait counter; must satisfy 2^CW > WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  Instr holds a valid fetched word this cycle
- Instr  in  32  instruction word: cond[31:28] op[27:26] funct[25:20] Rd[15:12]
- ALUFlags  in  4  datapath ALU flags {N,Z,C,V} = [3:0]
- mem_ack  in  1  data memory completed the current access
- PCWrite, PCSrc, MemtoReg, ALUSrc, RegWrite, MemWrite, mem_req  out  1 each  datapath/memory controls
- ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 pass-B
- ImmSrc  out  2  00 DP imm8, 01 mem imm12, 10 branch imm24
- RegSrc  out  2  bit0 = RA1 from PC, bit1 = RA2 from Rd
- Flags  out  4  registered NZCV
- state  out  2  00 FETCH, 01 EXEC, 10 MEM, 11 FAULT
- fault  out  1  high in FAULT

Behaviour:
- Reset (rst = 0, async): state = FETCH, IR = 0, Flags = 0000, wait counter = 0. All outputs are 0 while reset is asserted and in the first FETCH cycle. A reset during MEM drops mem_req immediately.
- FETCH:
  - All controls 0.
  - If instr_valid, latch Instr into IR and go to EXEC; otherwise stay in FETCH.
- EXEC (all controls decoded from IR; combinational from state + IR):
  - CondEx: standard ARM cond decode (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL) against Flags; 1111 is treated as never.
  - CondEx = 0: PCWrite = 1, PCSrc = 0, all write enables 0, Flags unchanged; go to FETCH.
  - DP (op = 00), cmd = funct[4:1]:
    - Commands: AND 0000, SUB 0010, ADD 0100, ORR 1100, CMP 1010, MOV 1101. Any other cmd → FAULT.
    - ALUSrc = IR[25]; ImmSrc = 00.
    - RegWrite = 1 unless CMP or Rd = 15.
    - Rd = 15 with a writing cmd: PCSrc = 1.
    - PCWrite = 1; next state FETCH.
  - Flag update at the EXEC clock edge when S = funct[0] = 1 or cmd = CMP: N, Z always from ALUFlags; C, V only for ADD/SUB/CMP, otherwise held.
  - MEM op (op = 01):
    - ALUSrc = 1; ImmSrc = 01.
    - ALUControl = ADD if U = IR[23] = 1, SUB otherwise.
    - RegSrc[1] = 1 for STR (L = funct[0] = 0).
    - Go to MEM; counter cleared. No PCWrite.
  - Branch (op = 10): ALUSrc = 1, ImmSrc = 10, RegSrc[0] = 1, ALUControl = ADD, PCSrc = 1, PCWrite = 1; go to FETCH.
  - op = 11: FAULT.
- MEM:
  - Hold the EXEC ALU/imm/RegSrc controls. mem_req = 1; MemWrite = ~L. Both stay stable until ack.
  - Counter increments each cycle without mem_ack.
  - On mem_ack: PCWrite = 1. For LDR, RegWrite = 1 and MemtoReg = 1 in the same cycle; if Rd = 15, also PCSrc = 1. Go to FETCH.
  - Counter reaching WAIT_LIMIT without ack: mem_req drops, go to FAULT.
  - mem_ack sampled in FETCH or EXEC is ignored.
- FAULT: sticky until reset. fault = 1; all other controls 0; instr_valid ignored.
- Throughput: DP/branch retire 2 cycles after instr_valid; LDR/STR take 3 + (ack wait) cycles.
- At most one PCWrite per instruction.

Optional Feature:
- Macro: ARMCTL_SINGLE_STEP_EN.
- When defined:
  - Adds input step_en (1b) and output retired (1b pulse, one cycle, coincident with PCWrite).
  - While step_en = 1, FETCH does not accept instr_valid until a new rising edge of step_en.
  - Net effect: one instruction per step_en rising edge, for the bring-up debugger.
- When undefined: no extra ports; FETCH accepts immediately.

Test Plan:
- Reset mid-MEM: STR with mem_ack held 0, pull rst low in cycle 3 → mem_req = 0 asynchronously; after release state = 00, Flags = 0000.
- ADDS R1,R2,#5 (0xE2921005) with ALUFlags = 0100 → EXEC: RegWrite = 1, ALUSrc = 1, ALUControl = 0000, PCWrite = 1; then Flags = 0100.
- BEQ (0x0A000002) with Flags Z = 0 → PCWrite = 1, PCSrc = 0, RegWrite = 0; with Z = 1 → PCSrc = 1, ImmSrc = 10, RegSrc = 01.
- LDR R3,[R4,#8] (0xE5943008), mem_ack after 3 cycles → mem_req high 3 cycles, MemWrite = 0, ack cycle: RegWrite = 1, MemtoReg = 1, PCWrite = 1.
- STR with WAIT_LIMIT = 4, no ack → MemWrite = 1 for 4 cycles, then state = 11, fault = 1; a later instr_valid is ignored.
- CMP R0,R0 (0xE1500000), ALUFlags = 0110 → RegWrite = 0, Flags = 0110; a following ORRS with ALUFlags = 1001 → Flags = 1010 (C held).
